// File: rtl/sys_bus_pkg.sv
// -----------------------------------------------------------------------------
// sys_bus_pkg
// Shared constants for the system bus controller: slot indices, the default
// address map (match value, mask, wait states per slot) and the wait-state
// counter width.
// -----------------------------------------------------------------------------
package sys_bus_pkg;

  localparam int WS_BITS = 3;

  localparam int SLOT_RAM  = 0;
  localparam int SLOT_ROM  = 1;
  localparam int SLOT_ACIA = 2;
  localparam int SLOT_VIA  = 3;

  localparam int DEF_NUM_SLOTS = 4;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  byte_t;

  // Index 0 is the first element; lower index has decode priority.
  localparam addr_t DEF_SLOT_BASE [DEF_NUM_SLOTS] =
    '{16'h0000, 16'hC000, 16'h8000, 16'h8800};
  localparam addr_t DEF_SLOT_MASK [DEF_NUM_SLOTS] =
    '{16'h8000, 16'hC000, 16'hFFF0, 16'hFFF0};
  localparam int    DEF_SLOT_WS   [DEF_NUM_SLOTS] =
    '{0, 0, 1, 3};

endpackage

// File: rtl/sys_clken_gen.sv
// -----------------------------------------------------------------------------
// sys_clken_gen
// CPU / peripheral clock-enable generator with wait-state stretching.
//   clk, resb     : system clock, asynchronous active-low reset
//   ws_load       : wait states of the slot addressed by the current access
//   cpu_clken     : one-clk pulse per CPU cycle (suppressed while wcnt != 0)
//   per_clken     : cpu_clken delayed by one clk
//   phi2          : external bus clock, MSB of the free-running counter
//   busy          : wait states pending
//   din_capture   : last clk of a non-stretched period, read data sampling point
// -----------------------------------------------------------------------------
module sys_clken_gen
  import sys_bus_pkg::*;
#(
  parameter int CLKEN_BITS = 4
) (
  input  logic               clk,
  input  logic               resb,
  input  logic [WS_BITS-1:0] ws_load,
  output logic               cpu_clken,
  output logic               per_clken,
  output logic               phi2,
  output logic               busy,
  output logic               din_capture
);

  if (CLKEN_BITS < 2) begin : g_bad_clken_bits
    $error("sys_clken_gen: CLKEN_BITS must be at least 2");
  end

  typedef logic [CLKEN_BITS-1:0] ctr_t;

  ctr_t               ctr_q, ctr_d;
  logic [WS_BITS-1:0] wcnt_q, wcnt_d;
  logic               cpu_clken_q, cpu_clken_d;
  logic               per_clken_q, per_clken_d;
  // Blocks the pulse on the very first edge after reset, so the first
  // cpu_clken lands one full period after release rather than immediately.
  logic               armed_q, armed_d;

  // NOTE: every variable gets a default first, so no path leaves one unassigned
  // and no latch can be inferred.
  always_comb begin
    ctr_d       = ctr_q + 1'b1;
    armed_d     = 1'b1;
    cpu_clken_d = armed_q && (ctr_q == '0) && (wcnt_q == '0);
    per_clken_d = cpu_clken_q;
    wcnt_d      = wcnt_q;
    // per_clken is only ever high at ctr==2, so a load can never coincide
    // with the ctr==0 decrement.
    if (per_clken_q) begin
      wcnt_d = ws_load;
    end else if ((ctr_q == '0) && (wcnt_q != '0)) begin
      wcnt_d = wcnt_q - 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      ctr_q       <= '0;
      wcnt_q      <= '0;
      cpu_clken_q <= 1'b0;
      per_clken_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      ctr_q       <= ctr_d;
      wcnt_q      <= wcnt_d;
      cpu_clken_q <= cpu_clken_d;
      per_clken_q <= per_clken_d;
      armed_q     <= armed_d;
    end
  end

  assign cpu_clken   = cpu_clken_q;
  assign per_clken   = per_clken_q;
  assign phi2        = ctr_q[CLKEN_BITS-1];
  assign busy        = (wcnt_q != '0);
  assign din_capture = (ctr_q == '1) && (wcnt_q == '0);

endmodule

// File: rtl/sys_bus_ctrl.sv
// -----------------------------------------------------------------------------
// sys_bus_ctrl
// System bus controller: clock-enable generation, slot address decode with
// per-slot wait states, and the CPU read-data mux/register.
//   clk, resb   : system clock, asynchronous active-low reset
//   cpu_addr    : registered CPU address
//   cpu_we      : registered CPU write enable
//   slot_rdata  : read data per slot, slot i at [8i+7:8i]
//   ext_din     : external data bus input
//   cpu_clken   : CPU clock enable pulse
//   per_clken   : peripheral enable, one clk after cpu_clken
//   phi2        : external bus clock
//   slot_sel    : one-hot slot decode (lowest index wins), combinational
//   slot_stb    : one-clk access strobe per slot
//   ext_sel     : no slot hit, access goes to the external bus
//   ext_dout_en : drive the external data bus
//   cpu_din     : registered CPU read data
//   busy        : wait states pending
// -----------------------------------------------------------------------------
module sys_bus_ctrl
  import sys_bus_pkg::*;
#(
  parameter int    CLKEN_BITS = 4,
  parameter int    NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter addr_t SLOT_BASE [NUM_SLOTS] = DEF_SLOT_BASE,
  parameter addr_t SLOT_MASK [NUM_SLOTS] = DEF_SLOT_MASK,
  parameter int    SLOT_WS   [NUM_SLOTS] = DEF_SLOT_WS
) (
  input  logic                   clk,
  input  logic                   resb,
  input  logic [15:0]            cpu_addr,
  input  logic                   cpu_we,
  input  logic [8*NUM_SLOTS-1:0] slot_rdata,
  input  logic [7:0]             ext_din,
  output logic                   cpu_clken,
  output logic                   per_clken,
  output logic                   phi2,
  output logic [NUM_SLOTS-1:0]   slot_sel,
  output logic [NUM_SLOTS-1:0]   slot_stb,
  output logic                   ext_sel,
  output logic                   ext_dout_en,
  output logic [7:0]             cpu_din,
  output logic                   busy
);

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_ws_check
    if ((SLOT_WS[g] < 0) || (SLOT_WS[g] > (1 << WS_BITS) - 1)) begin : g_bad_ws
      $error("sys_bus_ctrl: SLOT_WS entry out of range 0..7");
    end
  end

  logic               hit;
  logic [WS_BITS-1:0] ws_load;
  byte_t              rd_mux;
  logic               din_capture;
  byte_t              cpu_din_q, cpu_din_d;

  // Priority decode: the first matching slot claims the access and also picks
  // the wait-state count and read-data byte, so all three stay consistent.
  always_comb begin
    slot_sel = '0;
    hit      = 1'b0;
    ws_load  = '0;
    rd_mux   = ext_din;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit && ((cpu_addr & SLOT_MASK[i]) == SLOT_BASE[i])) begin
        hit         = 1'b1;
        slot_sel[i] = 1'b1;
        ws_load     = WS_BITS'(SLOT_WS[i]);
        rd_mux      = slot_rdata[8*i +: 8];
      end
    end
  end

  sys_clken_gen #(
    .CLKEN_BITS (CLKEN_BITS)
  ) u_clken_gen (
    .clk         (clk),
    .resb        (resb),
    .ws_load     (ws_load),
    .cpu_clken   (cpu_clken),
    .per_clken   (per_clken),
    .phi2        (phi2),
    .busy        (busy),
    .din_capture (din_capture)
  );

  // Sampled on the last clk of the (possibly stretched) access, then held so
  // it is stable across the following cpu_clken.
  always_comb begin
    cpu_din_d = din_capture ? rd_mux : cpu_din_q;
  end

  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      cpu_din_q <= '0;
    end else begin
      cpu_din_q <= cpu_din_d;
    end
  end

  assign cpu_din     = cpu_din_q;
  assign ext_sel     = ~hit;
  assign ext_dout_en = cpu_we & ~hit;
  assign slot_stb    = {NUM_SLOTS{per_clken}} & slot_sel;

endmodule

// File: tb/tb_sys_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sys_bus_ctrl
// Self-checking bench for sys_bus_ctrl with default parameters, plus a second
// instance with an overlapping slot-0 decode for priority checks.
// -----------------------------------------------------------------------------
module tb_sys_bus_ctrl;

  localparam int P = 16;  // CPU period with CLKEN_BITS = 4

  logic        clk = 1'b0;
  logic        resb = 1'b1;
  logic [15:0] cpu_addr = 16'h1234;
  logic        cpu_we = 1'b0;
  logic [31:0] slot_rdata = 32'hA55AC311;  // VIA=A5 ACIA=5A ROM=C3 RAM=11
  logic [7:0]  ext_din = 8'h00;

  logic       cpu_clken, per_clken, phi2, ext_sel, ext_dout_en, busy;
  logic [3:0] slot_sel, slot_stb;
  logic [7:0] cpu_din;

  logic       o2_cpu_clken, o2_per_clken, o2_phi2, o2_ext_sel, o2_ext_dout_en, o2_busy;
  logic [3:0] o2_slot_sel, o2_slot_stb;
  logic [7:0] o2_cpu_din;

  sys_bus_ctrl dut (
    .clk(clk), .resb(resb), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .slot_rdata(slot_rdata), .ext_din(ext_din),
    .cpu_clken(cpu_clken), .per_clken(per_clken), .phi2(phi2),
    .slot_sel(slot_sel), .slot_stb(slot_stb), .ext_sel(ext_sel),
    .ext_dout_en(ext_dout_en), .cpu_din(cpu_din), .busy(busy)
  );

  sys_bus_ctrl #(
    .SLOT_BASE('{16'h8000, 16'hC000, 16'h8000, 16'h8800}),
    .SLOT_MASK('{16'hF000, 16'hC000, 16'hFFF0, 16'hFFF0})
  ) dut2 (
    .clk(clk), .resb(resb), .cpu_addr(cpu_addr), .cpu_we(cpu_we),
    .slot_rdata(slot_rdata), .ext_din(ext_din),
    .cpu_clken(o2_cpu_clken), .per_clken(o2_per_clken), .phi2(o2_phi2),
    .slot_sel(o2_slot_sel), .slot_stb(o2_slot_stb), .ext_sel(o2_ext_sel),
    .ext_dout_en(o2_ext_dout_en), .cpu_din(o2_cpu_din), .busy(o2_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] m_base [4] = '{16'h0000, 16'hC000, 16'h8000, 16'h8800};
  logic [15:0] m_mask [4] = '{16'h8000, 16'hC000, 16'hFFF0, 16'hFFF0};
  int          m_ws   [4] = '{0, 0, 1, 3};

  function automatic int m_decode(input logic [15:0] a);
    for (int i = 0; i < 4; i++) begin
      if ((a & m_mask[i]) == m_base[i]) return i;
    end
    return -1;
  endfunction

  int         m_ctr = 0, m_wcnt = 0;
  bit         m_clk = 0, m_per = 0, m_started = 0;
  logic [7:0] m_din = 8'h00;

  always @(posedge clk or negedge resb) begin : model
    int  s;
    bit  clk_n;
    int  w_n;
    if (!resb) begin
      m_ctr = 0; m_wcnt = 0; m_clk = 0; m_per = 0; m_started = 0; m_din = 8'h00;
    end else begin
      s     = m_decode(cpu_addr);
      clk_n = (m_ctr == 0) && (m_wcnt == 0) && m_started;
      w_n   = m_wcnt;
      if (m_per) w_n = (s < 0) ? 0 : m_ws[s];
      else if (m_ctr == 0 && m_wcnt != 0) w_n = m_wcnt - 1;
      if (m_ctr == P - 1 && m_wcnt == 0) m_din = (s < 0) ? ext_din : slot_rdata[8*s +: 8];
      m_per     = m_clk;
      m_clk     = clk_n;
      m_wcnt    = w_n;
      m_ctr     = (m_ctr + 1) % P;
      m_started = 1;
    end
  end

  always @(negedge clk) begin : cmp
    int         s;
    logic [3:0] es;
    s  = m_decode(cpu_addr);
    es = (s < 0) ? 4'b0000 : 4'(1 << s);
    check("phi2",        phi2,        m_ctr >= P / 2);
    check("cpu_clken",   cpu_clken,   m_clk);
    check("per_clken",   per_clken,   m_per);
    check("busy",        busy,        m_wcnt != 0);
    check("slot_sel",    slot_sel,    es);
    check("ext_sel",     ext_sel,     s < 0);
    check("ext_dout_en", ext_dout_en, cpu_we && (s < 0));
    check("slot_stb",    slot_stb,    m_per ? es : 4'b0000);
    check("cpu_din",     cpu_din,     m_din);
  end

  // ---------------- directed stimulus ----------------
  typedef struct {
    int len;     // negedges until the next cpu_clken
    int stb;     // cycles with any slot_stb
    int bsy;     // cycles with busy
    int ph;      // cycles with phi2 high
    int per_at;  // negedge index where per_clken was first seen
  } period_t;

  // Call just after a cpu_clken negedge; returns at the next cpu_clken negedge.
  task automatic run_period(output period_t r);
    r = '{default: 0};
    do begin
      @(negedge clk);
      r.len++;
      if (|slot_stb) r.stb++;
      if (busy) r.bsy++;
      if (phi2) r.ph++;
      if (per_clken && r.per_at == 0) r.per_at = r.len;
    end while (!cpu_clken && r.len < 200);
  endtask

  task automatic release_and_sync(input string name);
    int n;
    @(posedge clk); #2 resb = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cpu_clken && n < 100);
    // Edge 1 leaves reset, then one full period of ctr until the ctr==0 edge.
    check(name, n, P + 1);
    @(negedge clk);
  endtask

  period_t r;
  int      n;

  initial begin
    #1 resb = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_clkens",  {cpu_clken, per_clken, phi2, busy}, 4'b0000);
    check("rst_stb",     slot_stb, 4'b0000);

    release_and_sync("first_clken_edges");

    // Idle-ish running: 16-clk period, per_clken right after, phi2 50% duty.
    for (int k = 0; k < 3; k++) begin
      run_period(r);
      check("idle_len", r.len, 16);
      check("idle_per_at", r.per_at, 1);
      check("idle_phi2_high", r.ph, 8);
    end

    // RAM access.
    #1 cpu_addr = 16'h1234; #1;
    check("ram_sel", slot_sel, 4'b0001);
    run_period(r);
    check("ram_len", r.len, 16);
    check("ram_stb", r.stb, 1);
    check("ram_din", cpu_din, 8'h11);

    // ROM access.
    #1 cpu_addr = 16'hC010; #1;
    check("rom_sel", slot_sel, 4'b0010);
    run_period(r);
    check("rom_len", r.len, 16);
    check("rom_stb", r.stb, 1);
    check("rom_din", cpu_din, 8'hC3);

    // VIA read, 3 wait states: 4 periods; wcnt=3 loaded after ctr==2 and the
    // last decrement at the start of the 4th period -> busy 3*16-2 clk.
    #1 cpu_addr = 16'h8803; #1;
    check("via_sel", slot_sel, 4'b1000);
    run_period(r);
    check("via_len", r.len, 64);
    check("via_busy", r.bsy, 46);
    check("via_stb", r.stb, 1);
    check("via_din", cpu_din, 8'hA5);

    // External write then external read.
    #1 cpu_addr = 16'h9000; cpu_we = 1'b1; #1;
    check("ext_wr_sel", {ext_sel, ext_dout_en, slot_sel}, 6'b11_0000);
    run_period(r);
    check("ext_wr_stb", r.stb, 0);
    check("ext_wr_len", r.len, 16);
    #1 cpu_we = 1'b0; ext_din = 8'h3C; #1;
    check("ext_rd_doen", ext_dout_en, 1'b0);
    run_period(r);
    check("ext_rd_din", cpu_din, 8'h3C);

    // Overlap: default map sends 8005 to ACIA; dut2's wider slot 0 wins.
    #1 cpu_addr = 16'h8005; #1;
    check("acia_sel", slot_sel, 4'b0100);
    check("overlap_sel", o2_slot_sel, 4'b0001);
    run_period(r);
    check("acia_len", r.len, 32);
    check("acia_busy", r.bsy, 14);
    check("acia_din", cpu_din, 8'h5A);

    // Reset in the middle of a VIA stretch.
    #1 cpu_addr = 16'h8803;
    n = 0;
    while (m_wcnt != 2 && n < 200) begin @(negedge clk); n++; end
    check("via_busy_pre_rst", busy, 1'b1);
    #2 resb = 1'b0;
    #1;
    check("async_rst_ctl", {cpu_clken, per_clken, phi2, busy}, 4'b0000);
    check("async_rst_stb", slot_stb, 4'b0000);
    check("async_rst_din", cpu_din, 8'h00);
    cpu_addr = 16'h1234;
    repeat (2) @(posedge clk);
    release_and_sync("post_rst_first_clken");
    run_period(r);
    check("post_rst_len", r.len, 16);
    check("post_rst_busy", r.bsy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
